// File: rtl/norm_round_seq.sv
// Multi-cycle normalise-and-round stage: iterative left shift of STEP bits per cycle,
// round-to-nearest-even, renormalise on round carry, valid/ready on both sides.
module norm_round_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned GRS_W = 3,
  parameter int unsigned STEP  = 4,
  parameter int unsigned FW    = MAN_W + GRS_W + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [FW-1:0]    frac_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] frac_out,
  output logic             overflag,
  output logic             underflag,
  output logic             zeroflag,
  output logic             inexact
);

  localparam int unsigned XW   = EXP_W + 2;
  localparam int unsigned LZ_W = $clog2(FW + 1);
  localparam logic [XW-1:0] ExpMax = XW'((2 ** EXP_W) - 1);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e              r_state;
  logic [FW-1:0]       r_frac;
  logic [XW-1:0]       r_exp;
  logic                r_lost;
  logic                r_out_valid;
  logic [EXP_W-1:0]    r_exp_out;
  logic [MAN_W-1:0]    r_frac_out;
  logic                r_over, r_under, r_zero, r_inexact;

  logic [LZ_W-1:0]     w_lz, w_k;
  logic                w_found;
  logic [XW-1:0]       w_exp_sub;
  logic                w_uflow;
  logic [GRS_W-1:0]    w_grs;
  logic                w_rup;
  logic [MAN_W+1:0]    w_sig;
  logic [MAN_W-1:0]    w_man;
  logic [XW-1:0]       w_exp_rnd;
  logic                w_oflow;

  // Leading zeros counted below the carry bit, starting at the hidden position.
  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = FW - 2; i >= 0; i--) begin
      if (!w_found) begin
        if (r_frac[i]) w_found = 1'b1;
        else           w_lz    = w_lz + LZ_W'(1);
      end
    end
  end

  always_comb begin
    w_k       = (w_lz > LZ_W'(STEP)) ? LZ_W'(STEP) : w_lz;
    w_exp_sub = r_exp - XW'(w_k);
    w_uflow   = w_exp_sub[XW-1] | (w_exp_sub == '0);
    w_grs     = r_frac[GRS_W-1:0];
    w_rup     = w_grs[GRS_W-1] & ((|w_grs[GRS_W-2:0]) | r_frac[GRS_W]);
    w_sig     = {1'b0, r_frac[FW-2:GRS_W]} + (MAN_W+2)'(w_rup);
    w_man     = w_sig[MAN_W+1] ? w_sig[MAN_W:1] : w_sig[MAN_W-1:0];
    w_exp_rnd = r_exp + XW'(w_sig[MAN_W+1]);
    w_oflow   = !w_exp_rnd[XW-1] && (w_exp_rnd >= ExpMax);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_frac      <= '0;
      r_exp       <= '0;
      r_lost      <= 1'b0;
      r_out_valid <= 1'b0;
      r_exp_out   <= '0;
      r_frac_out  <= '0;
      r_over      <= 1'b0;
      r_under     <= 1'b0;
      r_zero      <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_lost <= 1'b0;
            r_exp  <= XW'(exp_in);
            if (frac_in == '0) begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
              r_exp_out   <= '0;
              r_frac_out  <= '0;
              r_over      <= 1'b0;
              r_under     <= 1'b0;
              r_zero      <= 1'b1;
              r_inexact   <= 1'b0;
            end else if (frac_in[FW-1]) begin
              // Carry out of the adder: shift right, fold the lost bit into sticky.
              r_frac  <= {1'b0, frac_in[FW-1:2], frac_in[1] | frac_in[0]};
              r_exp   <= XW'(exp_in) + XW'(1);
              r_lost  <= frac_in[0];
              r_state <= StRound;
            end else begin
              r_frac  <= frac_in;
              r_state <= StNorm;
            end
          end
        end
        StNorm: begin
          if (r_frac[FW-2]) begin
            r_state <= StRound;
          end else if (w_uflow) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_exp_out   <= '0;
            r_frac_out  <= '0;
            r_over      <= 1'b0;
            r_under     <= 1'b1;
            r_zero      <= 1'b0;
            r_inexact   <= 1'b0;
          end else begin
            r_frac <= r_frac << w_k;
            r_exp  <= w_exp_sub;
          end
        end
        StRound: begin
          r_state     <= StDone;
          r_out_valid <= 1'b1;
          r_under     <= 1'b0;
          r_zero      <= 1'b0;
          r_inexact   <= (|w_grs) | r_lost;
          r_over      <= w_oflow;
          r_exp_out   <= w_oflow ? '1 : w_exp_rnd[EXP_W-1:0];
          r_frac_out  <= w_oflow ? '0 : w_man;
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign exp_out   = r_exp_out;
  assign frac_out  = r_frac_out;
  assign overflag  = r_over;
  assign underflag = r_under;
  assign zeroflag  = r_zero;
  assign inexact   = r_inexact;

endmodule

// File: tb/tb_norm_round_seq.sv
// Directed bench for norm_round_seq at default parameters (FW=28).
module tb_norm_round_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  exp_in = '0;
  logic [27:0] frac_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  exp_out;
  logic [22:0] frac_out;
  logic        overflag, underflag, zeroflag, inexact;

  int n_checks = 0;
  int n_errors = 0;

  norm_round_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .exp_in   (exp_in),
    .frac_in  (frac_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .exp_out  (exp_out),
    .frac_out (frac_out),
    .overflag (overflag),
    .underflag(underflag),
    .zeroflag (zeroflag),
    .inexact  (inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags packed as {overflag, underflag, zeroflag, inexact}
  task automatic do_op(input string tag, input logic [7:0] e, input logic [27:0] f,
                       input int lat_exp, input logic [7:0] ee, input logic [22:0] ef,
                       input logic [3:0] efl);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    exp_in   = e;
    frac_in  = f;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk({tag, ".latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, ".exp_out"}, 32'(exp_out), 32'(ee));
    chk({tag, ".frac_out"}, 32'(frac_out), 32'(ef));
    chk({tag, ".flags"}, 32'({overflag, underflag, zeroflag, inexact}), 32'(efl));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int w;
    int seen;
    // Reset state
    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'({exp_out, frac_out}), 32'd0);
    chk("rst.flags", 32'({overflag, underflag, zeroflag, inexact}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    do_op("norm0",   8'h80, 28'h4000000, 3, 8'h80, 23'h0, 4'b0000);
    do_op("carry",   8'h7F, 28'h8000000, 2, 8'h80, 23'h0, 4'b0000);
    do_op("carry_st", 8'h10, 28'h8000001, 2, 8'h11, 23'h0, 4'b0001);
    do_op("lz23",    8'h80, 28'h0000008, 9, 8'h69, 23'h0, 4'b0000);
    do_op("lz4",     8'h80, 28'h0400000, 4, 8'h7C, 23'h0, 4'b0000);
    do_op("tie_odd", 8'h80, 28'h7FFFFFC, 3, 8'h81, 23'h0, 4'b0001);
    do_op("tie_even", 8'h80, 28'h4000004, 3, 8'h80, 23'h0, 4'b0001);
    do_op("rnd_up",  8'h80, 28'h4000005, 3, 8'h80, 23'h1, 4'b0001);
    do_op("ovf",     8'hFE, 28'h8000000, 2, 8'hFF, 23'h0, 4'b1000);
    do_op("ufl",     8'h03, 28'h0000008, 2, 8'h00, 23'h0, 4'b0100);
    do_op("zero",    8'h55, 28'h0000000, 1, 8'h00, 23'h0, 4'b0010);

    // Backpressure: result must hold while out_ready stays low
    in_valid = 1'b1; exp_in = 8'h80; frac_in = 28'h4000005;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin tick(); w++; end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      chk("hold.data", 32'({exp_out, frac_out}), 32'({8'h80, 23'h1}));
      chk("hold.flags", 32'({overflag, underflag, zeroflag, inexact}), 32'b0001);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of NORM discards the operand
    in_valid = 1'b1; exp_in = 8'h80; frac_in = 28'h0000008;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort.no_result", 32'(seen), 32'd0);

    do_op("recover", 8'h7F, 28'h8000000, 2, 8'h80, 23'h0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
